// File: rtl/wash_sequencer.sv
// ---------------------------------------------------------------------------
// wash_sequencer
//
// Washing machine cycle controller. One program runs a detergent fill, an
// agitation phase and a drain. Then RINSE_CNT refill/agitate/drain passes
// follow, then a timed spin. A one-cycle done pulse ends the program.
// Opening the door while it is locked always aborts into FAULT, which is
// left only through clear_fault.
//
// Every output is decoded from registered state, so a change on an input
// shows up on the outputs one clock later. This includes the pause input,
// which is registered before it gates the motor.
//
// Optional feature (compile-time macro FILL_TIMEOUT_EN):
//   defined   : the phase timer runs in FILL. If water_full is still low in
//               the FILL_LIMIT-th cycle, the sequencer drops into FAULT.
//   undefined : FILL waits indefinitely for water_full.
//
// Parameters
//   CNT_W       width of the phase timer
//   WASH_TICKS  unpaused cycles per WASH phase      (1 .. 2^CNT_W-1)
//   SPIN_TICKS  unpaused cycles of SPIN             (1 .. 2^CNT_W-1)
//   RINSE_CNT   rinse passes after the soap wash    (0 .. 15)
//   FILL_LIMIT  FILL cycles before timeout fault    (1 .. 2^CNT_W-1)
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous, active-low reset
//   start          begin a program (honoured in IDLE only)
//   door_closed    door switch; low while locked -> FAULT
//   water_full     drum level reached
//   detergent_ack  detergent dispensed
//   drained        drum empty
//   pause          freezes agitation/spin timing and stops the motor
//   clear_fault    leave FAULT
//   door_lock, fill_valve, drain_valve, motor_on, detergent_req
//                  actuator commands
//   done           one-cycle end-of-program pulse
//   fault          high while in FAULT
//   state          current state code (IDLE=0 .. FAULT=7)
//   rinse_left     rinse passes still to run
// ---------------------------------------------------------------------------
module wash_sequencer #(
    parameter int CNT_W      = 16,
    parameter int WASH_TICKS = 1000,
    parameter int SPIN_TICKS = 500,
    parameter int RINSE_CNT  = 2,
    parameter int FILL_LIMIT = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       door_closed,
    input  logic       water_full,
    input  logic       detergent_ack,
    input  logic       drained,
    input  logic       pause,
    input  logic       clear_fault,
    output logic       door_lock,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic       motor_on,
    output logic       detergent_req,
    output logic       done,
    output logic       fault,
    output logic [3:0] state,
    output logic [3:0] rinse_left
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FILL      = 4'd1,
        DETERGENT = 4'd2,
        WASH      = 4'd3,
        DRAIN     = 4'd4,
        SPIN      = 4'd5,
        DONE      = 4'd6,
        FAULT     = 4'd7
    } state_t;

`ifdef FILL_TIMEOUT_EN
    localparam bit FILL_TIMEOUT = 1'b1;
`else
    localparam bit FILL_TIMEOUT = 1'b0;
`endif

    // Timer values seen in the last cycle of each timed phase.
    localparam logic [CNT_W-1:0] WASH_LAST = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_LIMIT - 1);
    localparam logic [3:0]       RINSE_INIT = 4'(RINSE_CNT);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [3:0]       rinse_q;
    logic [3:0]       rinse_d;
    logic             soap_q;
    logic             soap_d;
    logic             pause_q;
    logic             timer_run;
    logic             door_locked;

    // Register update. The timer restarts on every state change. It only
    // advances when the current state asks for it, and it saturates
    // rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            rinse_q <= '0;
            soap_q  <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rinse_q <= rinse_d;
            soap_q  <= soap_d;
            pause_q <= pause;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_run && (timer_q != '1)) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    // Next-state logic. An open door in a locked state overrides every
    // other decision in the same cycle. The rinse and soap bookkeeping
    // from the normal path is therefore discarded when that happens.
    always_comb begin
        state_d     = state_q;
        rinse_d     = rinse_q;
        soap_d      = soap_q;
        timer_run   = 1'b0;
        door_locked = (state_q == FILL) || (state_q == DETERGENT) ||
                      (state_q == WASH) || (state_q == DRAIN) ||
                      (state_q == SPIN);

        case (state_q)
            IDLE: begin
                if (start && door_closed) begin
                    state_d = FILL;
                    rinse_d = RINSE_INIT;
                    soap_d  = 1'b0;
                end
            end
            FILL: begin
                timer_run = FILL_TIMEOUT;
                if (water_full) begin
                    state_d = soap_q ? WASH : DETERGENT;
                end else if (FILL_TIMEOUT && (timer_q == FILL_LAST)) begin
                    state_d = FAULT;
                end
            end
            DETERGENT: begin
                if (detergent_ack) begin
                    state_d = WASH;
                    soap_d  = 1'b1;
                end
            end
            WASH: begin
                if (!pause) begin
                    timer_run = 1'b1;
                    if (timer_q == WASH_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    if (rinse_q != 4'd0) begin
                        state_d = FILL;
                        rinse_d = rinse_q - 4'd1;
                    end else begin
                        state_d = SPIN;
                    end
                end
            end
            SPIN: begin
                if (!pause) begin
                    timer_run = 1'b1;
                    if (timer_q == SPIN_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        if (door_locked && !door_closed) begin
            state_d = FAULT;
            rinse_d = rinse_q;
            soap_d  = soap_q;
        end
    end

    // Moore output decode. The motor is gated by the registered pause so
    // that it reacts one cycle after the pause input, like everything else.
    always_comb begin
        door_lock     = 1'b0;
        fill_valve    = 1'b0;
        drain_valve   = 1'b0;
        motor_on      = 1'b0;
        detergent_req = 1'b0;
        done          = 1'b0;
        fault         = 1'b0;
        case (state_q)
            FILL: begin
                door_lock  = 1'b1;
                fill_valve = 1'b1;
            end
            DETERGENT: begin
                door_lock     = 1'b1;
                detergent_req = 1'b1;
            end
            WASH: begin
                door_lock = 1'b1;
                motor_on  = !pause_q;
            end
            DRAIN: begin
                door_lock   = 1'b1;
                drain_valve = 1'b1;
            end
            SPIN: begin
                door_lock   = 1'b1;
                drain_valve = 1'b1;
                motor_on    = !pause_q;
            end
            DONE: begin
                done = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                door_lock = 1'b0;
            end
        endcase
    end

    assign state      = state_q;
    assign rinse_left = rinse_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wash_sequencer
//
// Testbench for wash_sequencer. It drives two instances:
//   A : default timing (WASH 1000, SPIN 500, two rinse passes)
//   B : short timing   (WASH 4, SPIN 2, no rinse, FILL_LIMIT 20)
// A phase-level model predicts every output of both instances each cycle.
// The model tracks phase, time spent in the phase, unpaused work done and
// remaining rinses. Visit order and phase lengths are also recorded from
// instance outputs and compared with hand-computed literals. The bench
// follows FILL_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_wash_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic       start_s   [2];
    logic       door_s    [2];
    logic       wfull_s   [2];
    logic       ack_s     [2];
    logic       drained_s [2];
    logic       pause_s   [2];
    logic       clrf_s    [2];
    logic       lock_o    [2];
    logic       fill_o    [2];
    logic       drain_o   [2];
    logic       motor_o   [2];
    logic       det_o     [2];
    logic       done_o    [2];
    logic       fault_o   [2];
    logic [3:0] state_o   [2];
    logic [3:0] rinse_o   [2];

    wash_sequencer #(
        .CNT_W(16), .WASH_TICKS(1000), .SPIN_TICKS(500),
        .RINSE_CNT(2), .FILL_LIMIT(2000)
    ) dut_a (
        .clk(clk), .reset(reset),
        .start(start_s[0]), .door_closed(door_s[0]), .water_full(wfull_s[0]),
        .detergent_ack(ack_s[0]), .drained(drained_s[0]), .pause(pause_s[0]),
        .clear_fault(clrf_s[0]),
        .door_lock(lock_o[0]), .fill_valve(fill_o[0]), .drain_valve(drain_o[0]),
        .motor_on(motor_o[0]), .detergent_req(det_o[0]), .done(done_o[0]),
        .fault(fault_o[0]), .state(state_o[0]), .rinse_left(rinse_o[0])
    );

    wash_sequencer #(
        .CNT_W(16), .WASH_TICKS(4), .SPIN_TICKS(2),
        .RINSE_CNT(0), .FILL_LIMIT(20)
    ) dut_b (
        .clk(clk), .reset(reset),
        .start(start_s[1]), .door_closed(door_s[1]), .water_full(wfull_s[1]),
        .detergent_ack(ack_s[1]), .drained(drained_s[1]), .pause(pause_s[1]),
        .clear_fault(clrf_s[1]),
        .door_lock(lock_o[1]), .fill_valve(fill_o[1]), .drain_valve(drain_o[1]),
        .motor_on(motor_o[1]), .detergent_req(det_o[1]), .done(done_o[1]),
        .fault(fault_o[1]), .state(state_o[1]), .rinse_left(rinse_o[1])
    );

    localparam int WASH_T [2] = '{1000, 4};
    localparam int SPIN_T [2] = '{500, 2};
    localparam int RINSES [2] = '{2, 0};
    localparam int FILL_L [2] = '{2000, 20};
`ifdef FILL_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    // Phase-level model: phase code, cycles already spent in the phase,
    // unpaused cycles of work completed, rinses still owed.
    typedef struct {
        int phase;
        int elapsed;
        int work;
        int rinses;
        bit soaped;
        bit paused_last;
    } model_t;

    model_t mdl [2];
    bit     auto_resp [2];

    int vectors     = 0;
    int miscompares = 0;
    int vis_q [$];
    int len_q [$];
    int rec_sel, rec_last, rec_run, motor_off, done_cnt;

    localparam int ORDER_A [13] = '{1, 2, 3, 4, 1, 3, 4, 1, 3, 4, 5, 6, 0};
    localparam int ORDER_B [7]  = '{1, 2, 3, 4, 5, 6, 0};

    function automatic model_t model_reset();
        model_t m;
        m.phase = 0; m.elapsed = 0; m.work = 0; m.rinses = 0;
        m.soaped = 1'b0; m.paused_last = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, int idx, bit st, bit dr,
                                          bit wf, bit ak, bit dn, bit ps, bit cf);
        model_t n;
        int     goal;
        n = m;
        case (m.phase)
            0: if (st && dr) begin
                   n.phase = 1; n.rinses = RINSES[idx]; n.soaped = 1'b0;
               end
            1: if (wf) n.phase = m.soaped ? 3 : 2;
               else if (TIMEOUT_ON && (m.elapsed + 1 == FILL_L[idx])) n.phase = 7;
            2: if (ak) begin n.phase = 3; n.soaped = 1'b1; end
            3, 5: begin
                goal = (m.phase == 3) ? WASH_T[idx] : SPIN_T[idx];
                if (!ps) begin
                    n.work = m.work + 1;
                    if (n.work == goal) n.phase = m.phase + 1 + (m.phase == 5 ? 0 : 0);
                end
            end
            4: if (dn) begin
                   if (m.rinses > 0) begin n.phase = 1; n.rinses = m.rinses - 1; end
                   else n.phase = 5;
               end
            6: n.phase = 0;
            7: if (cf) n.phase = 0;
            default: n.phase = 7;
        endcase
        if ((m.phase >= 1) && (m.phase <= 5) && !dr) begin
            n = m;
            n.phase = 7;
        end
        n.paused_last = ps;
        if (n.phase != m.phase) begin
            n.elapsed = 0;
            n.work    = 0;
        end else begin
            n.elapsed = m.elapsed + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) mdl[i] = model_reset();
        end else begin
            for (int i = 0; i < 2; i++)
                mdl[i] = model_step(mdl[i], i, start_s[i], door_s[i], wfull_s[i],
                                    ack_s[i], drained_s[i], pause_s[i], clrf_s[i]);
        end
    end

    // Plant responder: water is full on the 3rd FILL cycle, the dispenser
    // acks on the 2nd DETERGENT cycle, the drum is empty on the 4th DRAIN cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            wfull_s[i]   = auto_resp[i] && (mdl[i].phase == 1) && (mdl[i].elapsed >= 2);
            ack_s[i]     = (mdl[i].phase == 2) && (mdl[i].elapsed >= 1);
            drained_s[i] = (mdl[i].phase == 4) && (mdl[i].elapsed >= 3);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareModel();
        string p;
        int    ph;
        for (int i = 0; i < 2; i++) begin
            p  = (i == 0) ? "A" : "B";
            ph = mdl[i].phase;
            checkOutput({p, ".state"},  int'(state_o[i]), ph);
            checkOutput({p, ".rinse"},  int'(rinse_o[i]), mdl[i].rinses);
            checkOutput({p, ".lock"},   int'(lock_o[i]),  int'(ph >= 1 && ph <= 5));
            checkOutput({p, ".fill"},   int'(fill_o[i]),  int'(ph == 1));
            checkOutput({p, ".det"},    int'(det_o[i]),   int'(ph == 2));
            checkOutput({p, ".drain"},  int'(drain_o[i]), int'(ph == 4 || ph == 5));
            checkOutput({p, ".motor"},  int'(motor_o[i]),
                        int'((ph == 3 || ph == 5) && !mdl[i].paused_last));
            checkOutput({p, ".done"},   int'(done_o[i]),  int'(ph == 6));
            checkOutput({p, ".fault"},  int'(fault_o[i]), int'(ph == 7));
        end
    endtask

    // Advance one or more cycles, comparing against the model and recording
    // the visit history of the selected instance at each falling edge.
    task automatic applyStimulus(input int cycles);
        int cur;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            compareModel();
            cur = int'(state_o[rec_sel]);
            if (cur != rec_last) begin
                vis_q.push_back(cur);
                len_q.push_back(rec_run);
                rec_run  = 1;
                rec_last = cur;
            end else begin
                rec_run++;
            end
            if ((cur == 3) && !motor_o[rec_sel]) motor_off++;
            if (done_o[rec_sel]) done_cnt++;
        end
    endtask

    task automatic recClear(input int sel);
        vis_q.delete();
        len_q.delete();
        rec_sel   = sel;
        rec_last  = int'(state_o[sel]);
        rec_run   = 0;
        motor_off = 0;
        done_cnt  = 0;
    endtask

    task automatic waitState(input int idx, input int target, input int limit, input string name);
        int n;
        n = 0;
        while ((int'(state_o[idx]) != target) && (n < limit)) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(name, int'(state_o[idx]), target);
    endtask

    task automatic checkLen(input string name, input int visit, input int expected);
        if (visit + 1 < len_q.size()) checkOutput(name, len_q[visit + 1], expected);
        else checkOutput(name, -1, expected);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; door_s[i] = 1'b1; pause_s[i] = 1'b0;
            clrf_s[i] = 1'b0; auto_resp[i] = 1'b1;
        end
        rec_sel = 0; rec_last = 0; rec_run = 0; motor_off = 0; done_cnt = 0;
        #1 reset = 1'b0;

        // start held while in reset must not leave IDLE early
        start_s[0] = 1'b1;
        applyStimulus(2);
        checkOutput("reset_state", int'(state_o[0]), 0);
        checkOutput("reset_lock", int'(lock_o[0]), 0);
        recClear(0);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("first_edge_fill", int'(state_o[0]), 1);
        start_s[0] = 1'b0;

        // full default program
        waitState(0, 0, 6000, "run1_end");
        checkOutput("run1_visits", vis_q.size(), 13);
        for (int k = 0; k < 13; k++)
            if (k < vis_q.size()) checkOutput($sformatf("run1_order[%0d]", k), vis_q[k], ORDER_A[k]);
        checkLen("run1_fill_len", 0, 3);
        checkLen("run1_det_len", 1, 2);
        checkLen("run1_wash1_len", 2, 1000);
        checkLen("run1_drain_len", 3, 4);
        checkLen("run1_wash2_len", 5, 1000);
        checkLen("run1_wash3_len", 8, 1000);
        checkLen("run1_spin_len", 10, 500);
        checkLen("run1_done_len", 11, 1);
        checkOutput("run1_done_pulses", done_cnt, 1);

        // pause during first WASH, then open the door in SPIN
        applyStimulus(3);
        recClear(0);
        start_s[0] = 1'b1;
        applyStimulus(1);
        start_s[0] = 1'b0;
        waitState(0, 3, 50, "run2_wash");
        applyStimulus(500);
        pause_s[0] = 1'b1;
        applyStimulus(50);
        pause_s[0] = 1'b0;
        waitState(0, 4, 2000, "run2_drain");
        checkLen("run2_wash_len", 2, 1050);
        checkOutput("run2_motor_off", motor_off, 50);
        waitState(0, 5, 5000, "run2_spin");
        applyStimulus(99);
        checkOutput("spin_cycle100", int'(state_o[0]), 5);
        door_s[0] = 1'b0;
        applyStimulus(1);
        checkOutput("door_fault_state", int'(state_o[0]), 7);
        checkOutput("door_fault_flag", int'(fault_o[0]), 1);
        checkOutput("door_fault_motor", int'(motor_o[0]), 0);
        checkOutput("door_fault_drain", int'(drain_o[0]), 0);
        door_s[0] = 1'b1;
        clrf_s[0] = 1'b1;
        applyStimulus(1);
        clrf_s[0] = 1'b0;
        checkOutput("clear_to_idle", int'(state_o[0]), 0);

        // asynchronous reset in the middle of WASH
        start_s[0] = 1'b1;
        applyStimulus(1);
        start_s[0] = 1'b0;
        waitState(0, 3, 50, "run3_wash");
        applyStimulus(200);
        start_s[0] = 1'b1;
        applyStimulus(1);
        checkOutput("start_ignored_wash", int'(state_o[0]), 3);
        start_s[0] = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("async_rst_state", int'(state_o[0]), 0);
        checkOutput("async_rst_rinse", int'(rinse_o[0]), 0);
        checkOutput("async_rst_lock", int'(lock_o[0]), 0);
        checkOutput("async_rst_motor", int'(motor_o[0]), 0);
        checkOutput("async_rst_drain", int'(drain_o[0]), 0);
        checkOutput("async_rst_fault", int'(fault_o[0]), 0);
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(2);

        // short program on instance B, no rinse passes
        recClear(1);
        start_s[1] = 1'b1;
        applyStimulus(1);
        start_s[1] = 1'b0;
        waitState(1, 0, 200, "runB_end");
        checkOutput("runB_visits", vis_q.size(), 7);
        for (int k = 0; k < 7; k++)
            if (k < vis_q.size()) checkOutput($sformatf("runB_order[%0d]", k), vis_q[k], ORDER_B[k]);
        checkLen("runB_fill_len", 0, 3);
        checkLen("runB_wash_len", 2, 4);
        checkLen("runB_spin_len", 4, 2);

        // FILL with water never arriving
        auto_resp[1] = 1'b0;
        recClear(1);
        start_s[1] = 1'b1;
        applyStimulus(1);
        start_s[1] = 1'b0;
`ifdef FILL_TIMEOUT_EN
        waitState(1, 7, 100, "fill_timeout");
        checkLen("fill_timeout_len", 0, 20);
`else
        applyStimulus(5000);
        checkOutput("fill_wait_state", int'(state_o[1]), 1);
        checkOutput("fill_wait_visits", vis_q.size(), 1);
        door_s[1] = 1'b0;
        applyStimulus(1);
        checkOutput("fill_door_fault", int'(fault_o[1]), 1);
`endif
        door_s[1] = 1'b1;
        clrf_s[1] = 1'b1;
        applyStimulus(1);
        clrf_s[1] = 1'b0;
        checkOutput("runB_clear_idle", int'(state_o[1]), 0);
        auto_resp[1] = 1'b1;
        applyStimulus(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the internal phase timer.
REQ-002 Parameter WASH_TICKS, default 1000, unpaused clk cycles per WASH/RINSE agitation phase, 1..2^CNT_W-1.
REQ-003 Parameter SPIN_TICKS, default 500, unpaused clk cycles of SPIN, 1..2^CNT_W-1.
REQ-004 Parameter RINSE_CNT, default 2, rinse passes after the soap wash, 0..15.
REQ-005 Parameter FILL_LIMIT, default 2000, max cycles in FILL before fault (only with FILL_TIMEOUT_EN), 1..2^CNT_W-1.
REQ-006 clk  in  1  clock, all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start, door_closed, water_full, detergent_ack, drained, pause, clear_fault  in  1 each  synchronous level inputs.
REQ-009 door_lock, fill_valve, drain_valve, motor_on, detergent_req  out  1 each  actuator commands.
REQ-010 done  out  1  one-cycle completion pulse; fault  out  1  fault indication.
REQ-011 state  out  4  current state encoding; rinse_left  out  4  remaining rinse passes.

Function
REQ-012 States SHALL be IDLE=0, FILL=1, DETERGENT=2, WASH=3, DRAIN=4, SPIN=5, DONE=6, FAULT=7; codes 8-15 SHALL go to FAULT next cycle.
REQ-013 All outputs SHALL be Moore functions of registered state/counters, so they change one cycle after the triggering input.
REQ-014 IDLE: all actuators 0; start=1 and door_closed=1 -> FILL, load rinse_left=RINSE_CNT, clear soap_done flag; start in any other state ignored.
REQ-015 door_lock=1 in FILL, DETERGENT, WASH, DRAIN, SPIN; 0 in IDLE, DONE, FAULT.
REQ-016 FILL: fill_valve=1; on water_full -> DETERGENT if soap_done=0, else WASH.
REQ-017 DETERGENT: detergent_req=1; on detergent_ack -> WASH and set soap_done=1.
REQ-018 WASH: motor_on=1 unless pause=1; timer increments only when pause=0; transition to DRAIN in the cycle the timer equals WASH_TICKS-1 with pause=0.
REQ-019 DRAIN: drain_valve=1; on drained: rinse_left>0 -> FILL and rinse_left decrements in that cycle; rinse_left=0 -> SPIN.
REQ-020 SPIN: drain_valve=1, motor_on=1 unless pause=1; timer as REQ-018 with SPIN_TICKS -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 Timer SHALL clear to 0 on every state entry; it never wraps.
REQ-023 door_closed=0 in any door-locked state -> FAULT; this has priority over every other transition condition in the same cycle.
REQ-024 FAULT: fault=1, all actuators 0, door_lock=0; clear_fault=1 -> IDLE; start ignored.
REQ-025 pause SHALL have no effect in IDLE, FILL, DETERGENT, DRAIN, DONE, FAULT.
REQ-026 RINSE_CNT=0: sequence SHALL be FILL, DETERGENT, WASH, DRAIN, SPIN, DONE.

Reset
REQ-027 reset=0 SHALL immediately force state=IDLE, timer=0, rinse_left=0, soap_done=0, all outputs 0, including mid-cycle.
REQ-028 First transition out of IDLE SHALL occur no earlier than the first rising edge after reset deasserts.

Configuration
REQ-029 Macro FILL_TIMEOUT_EN defined: timer runs in FILL; if water_full still 0 when timer equals FILL_LIMIT-1 -> FAULT.
REQ-030 FILL_TIMEOUT_EN undefined: FILL waits indefinitely; FILL_LIMIT unused; FAULT reachable only via REQ-012/REQ-023.

Verification
REQ-031 Defaults, start+door_closed, water_full each FILL after 3 cycles, ack 2 cycles, drained 4 cycles -> state order 1,2,3,4,1,3,4,1,3,4,5,6,0; WASH 1000 cycles each; SPIN 500; done high 1 cycle.
REQ-032 pause=1 for 50 cycles mid-WASH -> motor_on=0 during pause, WASH lasts 1050 cycles total.
REQ-033 door_closed=0 in SPIN at cycle 100 -> state=7 next cycle, fault=1, motor_on=0, drain_valve=0; clear_fault -> state=0.
REQ-034 FILL_TIMEOUT_EN defined, FILL_LIMIT=20, water_full held 0 -> FAULT after exactly 20 cycles in FILL; undefined -> remains FILL after 5000 cycles.
REQ-035 reset=0 asserted mid-WASH -> all outputs 0, state=0 without a clock edge; start during WASH ignored.
REQ-036 RINSE_CNT=0, WASH_TICKS=4, SPIN_TICKS=2 -> order 1,2,3,4,5,6,0; WASH 4 cycles, SPIN 2.
